rx_uart_module: RTL and testbench

RX_UART_MODULE -- requirements
Module: rx_uart_module

---
 rtl/rx_uart_module_if.sv | 28 ++
 rtl/rx_uart_module.sv | 113 +++++++++++
 tb/tb_rx_uart_module.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_uart_module_if.sv
// rtl/rx_uart_module_if.sv - serial line, enable and receive status bundle for rx_uart_module
// Master drives the line and enable; slave is the receiver.
interface rx_uart_module_if;
    logic       RX_Pin_In;
    logic       RX_En;
    logic [7:0] RX_Data;
    logic       RX_Done_Sig;
    logic       Frame_Err;
    logic       RX_Busy;

    modport master (
        output RX_Pin_In,
        output RX_En,
        input  RX_Data,
        input  RX_Done_Sig,
        input  Frame_Err,
        input  RX_Busy
    );

    modport slave (
        input  RX_Pin_In,
        input  RX_En,
        output RX_Data,
        output RX_Done_Sig,
        output Frame_Err,
        output RX_Busy
    );
endinterface

// File: rtl/rx_uart_module.sv
// rtl/rx_uart_module.sv - 8N1 UART receiver with mid-bit sampling and framing check
// The bit counter free-runs across START/DATA/STOP so every sample lands on a bit centre.
module rx_uart_module #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT >> 1
) (
    input  logic              CLK,
    input  logic              RST,
    rx_uart_module_if.slave   rx
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [12:0] CNT_LAST = 13'(CLKS_PER_BIT - 1);
    localparam logic [12:0] CNT_HALF = 13'(HALF_BIT);

    state_t      state_q, state_d;
    logic [2:0]  sync_q, sync_d;
    logic [12:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic        busy_q, busy_d;

    logic rx_s;
    logic fall;
    logic sample;
    logic abort;

    // sync_q[1] is the synchronized line, sync_q[2] its previous value
    assign rx_s   = sync_q[1];
    assign fall   = sync_q[2] & ~sync_q[1];
    assign sample = (cnt_q == CNT_HALF);
    assign abort  = (state_q != IDLE) && !rx.RX_En;
    assign sync_d = {sync_q[1:0], rx.RX_Pin_In};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            sync_q    <= 3'b111;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (rx.RX_En && fall) state_d = START;
                START: if (sample) state_d = rx_s ? IDLE : DATA;
                DATA:  if (sample && idx_q == 3'd7) state_d = STOP;
                STOP:  if (sample) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d     = '0;
        idx_d     = idx_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        busy_d    = (state_d != IDLE);
        if (state_q == IDLE || abort) begin
            idx_d = '0;
        end else begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 13'd1;
            if (sample) begin
                unique case (state_q)
                    START: idx_d = '0;
                    DATA: begin
                        shift_d[idx_q] = rx_s;
                        idx_d          = idx_q + 3'd1;
                    end
                    STOP: begin
                        done_d = rx_s;
                        ferr_d = ~rx_s;
                        if (rx_s) rx_data_d = shift_q;
                    end
                    default: idx_d = '0;
                endcase
            end
        end
    end

    assign rx.RX_Data     = rx_data_q;
    assign rx.RX_Done_Sig = done_q;
    assign rx.Frame_Err   = ferr_q;
    assign rx.RX_Busy     = busy_q;

endmodule

// File: tb/tb_rx_uart_module.sv
// tb/tb_rx_uart_module.sv - self-checking bench for rx_uart_module
// Frames are produced bit by bit; expectations come from the 8N1 framing rules and a last-good-byte model.
module tb_rx_uart_module;

    localparam int CPB  = 16;
    localparam int HALF = 8;
    // line fall -> 2 sync FFs + edge register -> START, then stop sample + registered pulse
    localparam int LAT  = 4 + HALF + 9 * CPB;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    int   done_cnt;
    int   ferr_cnt;
    int   last_pulse_cyc;
    int   fall_cyc;
    logic [7:0] last_done_data;
    logic [7:0] model_data;
    logic       abort_tx;

    rx_uart_module_if bus ();

    rx_uart_module #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .CLK (clk),
        .RST (rst),
        .rx  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.RX_Done_Sig || bus.Frame_Err)
            check("pulse_exclusive", 32'(bus.RX_Done_Sig & bus.Frame_Err), 32'd0);
        if (bus.RX_Done_Sig) begin
            done_cnt++;
            last_pulse_cyc = cyc;
            last_done_data = bus.RX_Data;
        end
        if (bus.Frame_Err) begin
            ferr_cnt++;
            last_pulse_cyc = cyc;
        end
    end

    task automatic idle(input int bits);
        bus.RX_Pin_In = 1'b1;
        repeat (bits * CPB) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        bits     = {stop_bit, d, 1'b0};
        fall_cyc = cyc;
        for (int b = 0; b < 10; b++) begin
            bus.RX_Pin_In = bits[b];
            for (int c = 0; c < CPB; c++) begin
                if (abort_tx) begin
                    bus.RX_Pin_In = 1'b1;
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input logic stop_ok, input int gap,
                             input logic exp_done, input logic exp_ferr,
                             input logic [7:0] exp_data, input string tag);
        int d0;
        int f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        idle(gap);
        send_frame(d, stop_ok);
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'(exp_done));
        check({tag, "_ferr_count"}, 32'(ferr_cnt - f0), 32'(exp_ferr));
        check({tag, "_rx_data"}, 32'(bus.RX_Data), 32'(exp_data));
        if (exp_done || exp_ferr)
            check({tag, "_latency"}, 32'(last_pulse_cyc - fall_cyc), 32'(LAT));
        if (exp_done)
            check({tag, "_pulse_data"}, 32'(last_done_data), 32'(exp_data));
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         gap;
        logic       exp_done;
        logic       exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int f0;
        int g0;
        logic prev_bad;

        vecs[0] = '{8'hA5, 1'b1, 2, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 1, 1'b1, 1'b0, 8'h3C};
        vecs[2] = '{8'hC3, 1'b1, 0, 1'b1, 1'b0, 8'hC3};
        vecs[3] = '{8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
        vecs[4] = '{8'h55, 1'b0, 0, 1'b0, 1'b1, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 1, 1'b1, 1'b0, 8'hFF};
        vecs[6] = '{8'h80, 1'b1, 0, 1'b1, 1'b0, 8'h80};
        vecs[7] = '{8'h01, 1'b0, 0, 1'b0, 1'b1, 8'h80};
        vecs[8] = '{8'h7F, 1'b1, 2, 1'b1, 1'b0, 8'h7F};

        tests = 0; fails = 0; done_cnt = 0; ferr_cnt = 0;
        last_pulse_cyc = 0; fall_cyc = 0; last_done_data = 8'h00;
        abort_tx = 1'b0;
        rst = 1'b1;
        bus.RX_Pin_In = 1'b1;
        bus.RX_En     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rx_data", 32'(bus.RX_Data), 32'h00);
        check("reset_done", 32'(bus.RX_Done_Sig), 32'd0);
        check("reset_ferr", 32'(bus.Frame_Err), 32'd0);
        check("reset_busy", 32'(bus.RX_Busy), 32'd0);
        rst = 1'b0;
        idle(2);
        check("post_reset_busy", 32'(bus.RX_Busy), 32'd0);
        check("post_reset_pulses", 32'(done_cnt + ferr_cnt), 32'd0);

        for (int i = 0; i < 9; i++)
            run_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].gap,
                      vecs[i].exp_done, vecs[i].exp_ferr, vecs[i].exp_data, $sformatf("vec%0d", i));
        model_data = 8'h7F;

        // short low glitch is rejected at the start-bit sample
        idle(2);
        d0 = done_cnt; f0 = ferr_cnt;
        g0 = cyc;
        bus.RX_Pin_In = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.RX_Pin_In = 1'b1;
        while (cyc != g0 + 11) @(negedge clk);
        check("glitch_busy_c8", 32'(bus.RX_Busy), 32'd1);
        @(negedge clk);
        check("glitch_busy_c9", 32'(bus.RX_Busy), 32'd0);
        @(posedge clk);
        #1;
        idle(2);
        check("glitch_pulses", 32'(done_cnt + ferr_cnt - d0 - f0), 32'd0);
        check("glitch_rx_data", 32'(bus.RX_Data), 32'(model_data));

        // bad stop followed by a long break, then recovery
        d0 = done_cnt; f0 = ferr_cnt;
        idle(1);
        send_frame(8'h55, 1'b0);
        repeat (40 * CPB) @(posedge clk);
        #1;
        check("break_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("break_done", 32'(done_cnt - d0), 32'd0);
        check("break_busy", 32'(bus.RX_Busy), 32'd0);
        check("break_rx_data", 32'(bus.RX_Data), 32'(model_data));
        run_frame(8'hA5, 1'b1, 2, 1'b1, 1'b0, 8'hA5, "after_break");
        model_data = 8'hA5;

        // disabled receiver ignores a whole frame
        bus.RX_En = 1'b0;
        d0 = done_cnt; f0 = ferr_cnt;
        idle(1);
        send_frame(8'h5A, 1'b1);
        check("disabled_busy", 32'(bus.RX_Busy), 32'd0);
        check("disabled_pulses", 32'(done_cnt + ferr_cnt - d0 - f0), 32'd0);
        bus.RX_En = 1'b1;

        // enable dropped during bit 3 aborts the frame
        idle(1);
        d0 = done_cnt; f0 = ferr_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (4 * CPB + 8) @(posedge clk);
                #1;
                check("abort_busy_before", 32'(bus.RX_Busy), 32'd1);
                bus.RX_En = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                check("abort_busy_after", 32'(bus.RX_Busy), 32'd0);
            end
        join
        bus.RX_En = 1'b1;
        idle(1);
        check("abort_pulses", 32'(done_cnt + ferr_cnt - d0 - f0), 32'd0);
        check("abort_rx_data", 32'(bus.RX_Data), 32'(model_data));
        run_frame(8'h12, 1'b1, 0, 1'b1, 1'b0, 8'h12, "after_abort");

        // reset during bit 5 of a frame
        idle(1);
        d0 = done_cnt; f0 = ferr_cnt;
        fork
            send_frame(8'h81, 1'b1);
            begin
                repeat (6 * CPB + 8) @(posedge clk);
                #1;
                check("rst_mid_busy_before", 32'(bus.RX_Busy), 32'd1);
                rst = 1'b1;
                abort_tx = 1'b1;
                #1;
                check("rst_mid_rx_data", 32'(bus.RX_Data), 32'h00);
                check("rst_mid_busy", 32'(bus.RX_Busy), 32'd0);
                check("rst_mid_done", 32'(bus.RX_Done_Sig), 32'd0);
                check("rst_mid_ferr", 32'(bus.Frame_Err), 32'd0);
            end
        join
        bus.RX_Pin_In = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        abort_tx = 1'b0;
        idle(2);
        check("rst_mid_pulses", 32'(done_cnt + ferr_cnt - d0 - f0), 32'd0);
        run_frame(8'h7E, 1'b1, 0, 1'b1, 1'b0, 8'h7E, "after_rst");
        model_data = 8'h7E;

        // randomized frames against the last-good-byte model
        prev_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            logic       ok;
            int         gap;
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 2);
            if (prev_bad && gap == 0) gap = 1;
            if (ok) model_data = d;
            run_frame(d, ok, gap, ok, !ok, model_data, $sformatf("rand%0d", i));
            prev_bad = !ok;
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
